// File: rtl/sub_result_stage.sv
// Registered unsigned subtract stage with a 2-entry skid FIFO of {y, borrow, ovf, zero}.
// Optional macro SUB_RESULT_SAT_EN: clamp y to 0 (zero=1) when the subtraction borrows.
module sub_result_stage #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         borrow,
    output logic         ovf,
    output logic         zero
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    typedef struct packed {
        logic [N-1:0] y;
        logic         borrow;
        logic         ovf;
        logic         zero;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          head_q, head_d;
    entry_t          new_e;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            push, pop;
    logic [N:0]      diff;

    // Result of the operand pair currently offered
    always_comb begin
        diff         = {1'b0, a} - {1'b0, b};
        new_e.y      = diff[N-1:0];
        new_e.borrow = diff[N];
        new_e.ovf    = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
`ifdef SUB_RESULT_SAT_EN
        if (diff[N]) begin
            new_e.y = '0;
        end
`endif
        new_e.zero   = (new_e.y == '0);
    end

    // Next-state: FIFO bookkeeping and the entry that will be head after the edge
    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = out_valid_q && out_ready;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        count_d     = count_q + CW'(push) - CW'(pop);
        head_d      = head_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_e;
        end
        if (count_d != '0) begin
            head_d = mem_d[rd_ptr_d];
        end
        in_ready_d  = (count_d < CW'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            head_q      <= head_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = head_q.y;
    assign borrow    = head_q.borrow;
    assign ovf       = head_q.ovf;
    assign zero      = head_q.zero;

endmodule

// File: doc/sub_result_stage.md
SUB_RESULT_STAGE -- requirements
Module: sub_result_stage

Interface
REQ-001 Parameter: N, default 8, operand and result width in bits (N >= 2).
REQ-002 Parameter: DEPTH, fixed at 2, number of buffered result entries (skid buffer), not overridable.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  upstream operand pair valid.
REQ-006 Port: in_ready  output  1  stage can accept an operand pair this cycle.
REQ-007 Port: a  input  N  minuend, unsigned.
REQ-008 Port: b  input  N  subtrahend, unsigned.
REQ-009 Port: out_valid  output  1  head entry valid.
REQ-010 Port: out_ready  input  1  downstream accepts head entry.
REQ-011 Port: y  output  N  head entry difference.
REQ-012 Port: borrow  output  1  head entry unsigned borrow (a < b).
REQ-013 Port: ovf  output  1  head entry two's-complement signed overflow of a - b.
REQ-014 Port: zero  output  1  head entry y == 0.

Function
REQ-015 Push occurs on a rising edge where in_valid && in_ready; pop occurs on a rising edge where out_valid && out_ready.
REQ-016 On push, the stage computes {borrow, y} = a - b at N+1 bits, ovf = (a[N-1] != b[N-1]) && (y[N-1] != a[N-1]), and zero = (y == 0), then stores all four fields as one entry.
REQ-017 Latency is 1 cycle: a pair pushed at edge k into an empty stage presents out_valid=1 with its results after edge k.
REQ-018 Entries leave in push order (FIFO); all outputs are driven from registers, with no combinational path from a/b to y.
REQ-019 Occupancy count ranges 0..2; in_ready = (count < 2), registered-derived, with no combinational dependence on out_ready.
REQ-020 out_valid = (count > 0); y/borrow/ovf/zero reflect the head entry and hold stable while out_valid && !out_ready.
REQ-021 Simultaneous push and pop at count 1: count stays 1, the new entry becomes head after the edge, and there is no bubble.
REQ-022 Simultaneous push and pop at count 0: not possible (out_valid=0); the push alone makes count 1.
REQ-023 At count 2, in_ready=0; a pop lowers count to 1 and in_ready rises the next cycle.
REQ-024 in_valid asserted while in_ready=0 has no effect; operands are not captured.
REQ-025 Pointer wrap: read and write pointers are 1 bit each and toggle on pop and push respectively.
REQ-026 When out_valid=0, y/borrow/ovf/zero hold their last values (don't-care for consumers).

Reset
REQ-027 rst_n low asynchronously sets count=0, both pointers=0, out_valid=0, in_ready=1, and y=0, borrow=0, ovf=0, zero=0.
REQ-028 Reset mid-operation discards all buffered entries; no pop or push completes on the edge coinciding with rst_n low.
REQ-029 The first push is accepted on the first rising edge with rst_n high.

Configuration
REQ-030 Macro SUB_RESULT_SAT_EN: when defined, a push whose borrow=1 stores y=0 and zero=1 (unsigned floor saturation); borrow and ovf are still stored unmodified.
REQ-031 Without SUB_RESULT_SAT_EN, y is the N-bit wrap-around difference, exactly per REQ-016.

Verification
REQ-032 N=8: push a=0x50,b=0x20 with out_ready=1 -> next cycle out_valid=1, y=0x30, borrow=0, ovf=0, zero=0.
REQ-033 N=8: push a=0x10,b=0x20 -> y=0xF0, borrow=1, ovf=0, zero=0; with SUB_RESULT_SAT_EN -> y=0x00, borrow=1, zero=1.
REQ-034 N=8: push a=0x80,b=0x01 -> y=0x7F, borrow=0, ovf=1; push a=0x33,b=0x33 -> y=0x00, zero=1.
REQ-035 out_ready=0, three back-to-back pushes (1-0, 2-0, 3-0) -> in_ready low after the 2nd push, 3rd not accepted, y=1 held; raise out_ready -> outputs 1, 2, then 3 once re-offered, in order.
REQ-036 Streaming: in_valid=1, out_ready=1 for 16 cycles with incrementing a, b=0 -> one result per cycle, no gaps, in_ready constantly 1.
REQ-037 Two entries buffered, pulse rst_n low mid-cycle -> out_valid=0 and in_ready=1 immediately (asynchronously), all outputs 0, no stale entry emitted afterward.
